// File: rtl/if_consumer_if.sv
// -----------------------------------------------------------------------------
// if_consumer_if
// Bundles the fetch-unit-to-consumer signals of if_consumer.
//   Fetch -> consumer : instruction_valid, instruction[31:0], pc[31:0],
//                       prediction, prediction_valid
//   Consumer -> fetch : stall, branch_resolved, branch_taken,
//                       branch_target[31:0], mispredict,
//                       retired_count[31:0], mispredict_count[15:0]
// Modports: master = fetch side, slave = if_consumer.
// -----------------------------------------------------------------------------
interface if_consumer_if;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        prediction;
    logic        prediction_valid;
    logic        stall;
    logic        branch_resolved;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mispredict;
    logic [31:0] retired_count;
    logic [15:0] mispredict_count;

    modport master (
        output instruction_valid, instruction, pc, prediction, prediction_valid,
        input  stall, branch_resolved, branch_taken, branch_target, mispredict,
        input  retired_count, mispredict_count
    );

    modport slave (
        input  instruction_valid, instruction, pc, prediction, prediction_valid,
        output stall, branch_resolved, branch_taken, branch_target, mispredict,
        output retired_count, mispredict_count
    );
endinterface

// File: rtl/if_consumer.sv
// -----------------------------------------------------------------------------
// if_consumer
// Accepts RV32 instructions from a fetch unit, resolves conditional branches
// after RESOLVE_LAT cycles (taken = funct3[0], target = pc + B-immediate),
// flags mispredictions against the fetch-side prediction, inserts a one-cycle
// flush stall after a mispredict, and issues a one-cycle periodic stall after
// every STALL_EVERY accepted non-branch instructions.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - if_consumer_if.slave (instruction/prediction in, stall and
//          branch outcome / statistics out; all outputs registered)
//
// Parameters:
//   RESOLVE_LAT - acceptance-to-resolve latency, 1..15
//   STALL_EVERY - non-branch accepts between periodic stalls, 0 = off
//
// Build option:
//   IF_CONSUMER_STATS_EN - when defined, retired_count and mispredict_count
//   are live wrapping counters; otherwise both are tied to zero.
// -----------------------------------------------------------------------------
module if_consumer #(
    parameter int unsigned RESOLVE_LAT = 2,
    parameter int unsigned STALL_EVERY = 8
) (
    input  logic         clk,
    input  logic         rst,
    if_consumer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [3:0]  LAT_L      = 4'(RESOLVE_LAT);
    localparam logic [15:0] EVERY_L    = 16'(STALL_EVERY);

    // Sign-extended B-type immediate.
    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [15:0] per_q, per_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic        tbit_q, tbit_d;
    logic        pred_q, pred_d;
    logic        pv_q, pv_d;
    logic        stall_q, stall_d;
    logic        resolved_q, resolved_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;
    logic        mis_q, mis_d;

    logic        accept_s;
    logic        is_branch_s;
    logic        resolve_now_s;
    logic [31:0] src_pc_s;
    logic [31:0] src_imm_s;
    logic        src_taken_s;
    logic        src_pred_s;

    // rs1/rs2/funct3[2:1] play no part in branch resolution.
    logic        unused_instr_s;
    assign unused_instr_s = ^bus.instruction[24:13];

    // Acceptance qualifier and branch decode of the presented instruction.
    always_comb begin
        accept_s    = bus.instruction_valid && !stall_q && (state_q == IDLE);
        is_branch_s = (bus.instruction[6:0] == OPC_BRANCH);
    end

    // Next-state, stall and periodic-counter logic.
    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        per_d         = per_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        tbit_d        = tbit_q;
        pred_d        = pred_q;
        pv_d          = pv_q;
        stall_d       = 1'b0;
        resolve_now_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s && is_branch_s) begin
                    // Branch does not advance the periodic counter.
                    pc_d          = bus.pc;
                    imm_d         = b_imm(bus.instruction);
                    tbit_d        = bus.instruction[12];
                    pred_d        = bus.prediction;
                    pv_d          = bus.prediction_valid;
                    lat_d         = 4'd1;
                    stall_d       = 1'b1;
                    state_d       = RESOLVE;
                    resolve_now_s = (LAT_L == 4'd1);
                end else if (accept_s) begin
                    if (EVERY_L == 16'd0) begin
                        per_d = per_q;
                    end else if ((per_q + 16'd1) == EVERY_L) begin
                        per_d   = 16'd0;
                        stall_d = 1'b1;
                    end else begin
                        per_d = per_q + 16'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RESOLVE: begin
                if (lat_q == LAT_L) begin
                    // This is the resolve cycle; mis_q holds its outcome.
                    state_d = mis_q ? FLUSH : IDLE;
                    stall_d = mis_q;
                    lat_d   = 4'd0;
                end else begin
                    lat_d         = lat_q + 4'd1;
                    stall_d       = 1'b1;
                    resolve_now_s = ((lat_q + 4'd1) == LAT_L);
                end
            end
            FLUSH: begin
                state_d = IDLE;
                stall_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                stall_d = 1'b0;
                lat_d   = 4'd0;
            end
        endcase
    end

    // Branch outcome; with RESOLVE_LAT=1 it resolves from the live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            src_pc_s    = bus.pc;
            src_imm_s   = b_imm(bus.instruction);
            src_taken_s = bus.instruction[12];
            src_pred_s  = bus.prediction_valid & bus.prediction;
        end else begin
            src_pc_s    = pc_q;
            src_imm_s   = imm_q;
            src_taken_s = tbit_q;
            src_pred_s  = pv_q & pred_q;
        end
        resolved_d = resolve_now_s;
        taken_d    = resolve_now_s & src_taken_s;
        target_d   = resolve_now_s ? (src_pc_s + src_imm_s) : 32'd0;
        mis_d      = resolve_now_s & (src_pred_s ^ src_taken_s);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_q      <= 4'd0;
            per_q      <= 16'd0;
            pc_q       <= 32'd0;
            imm_q      <= 32'd0;
            tbit_q     <= 1'b0;
            pred_q     <= 1'b0;
            pv_q       <= 1'b0;
            stall_q    <= 1'b0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            per_q      <= per_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            tbit_q     <= tbit_d;
            pred_q     <= pred_d;
            pv_q       <= pv_d;
            stall_q    <= stall_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
            mis_q      <= mis_d;
        end
    end

`ifdef IF_CONSUMER_STATS_EN
    logic [31:0] retired_q, retired_d;
    logic [15:0] mcount_q, mcount_d;

    // Wrapping statistics counters.
    always_comb begin
        retired_d = retired_q + {31'd0, accept_s};
        mcount_d  = mcount_q + {15'd0, mis_d};
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 32'd0;
            mcount_q  <= 16'd0;
        end else begin
            retired_q <= retired_d;
            mcount_q  <= mcount_d;
        end
    end

    assign bus.retired_count    = retired_q;
    assign bus.mispredict_count = mcount_q;
`else
    assign bus.retired_count    = 32'd0;
    assign bus.mispredict_count = 16'd0;
`endif

    assign bus.stall           = stall_q;
    assign bus.branch_resolved = resolved_q;
    assign bus.branch_taken    = taken_q;
    assign bus.branch_target   = target_q;
    assign bus.mispredict      = mis_q;

endmodule

// File: tb/tb_if_consumer.sv
`timescale 1ns/1ps
module tb_if_consumer;
    localparam int LAT   = 2;
    localparam int EVERY = 8;
    localparam int MAXC  = 4096;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_CONSUMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    if_consumer_if bus0();
    if_consumer_if bus1();

    if_consumer #(.RESOLVE_LAT(LAT), .STALL_EVERY(EVERY)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    if_consumer #(.RESOLVE_LAT(1), .STALL_EVERY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference schedule for dut0, indexed by cycle number (cycle c = after edge c).
    bit          m_stall [MAXC];
    bit          m_res   [MAXC];
    bit          m_taken [MAXC];
    logic [31:0] m_target[MAXC];
    bit          m_mis   [MAXC];
    int          m_ret_d [MAXC];
    int          m_mc_d  [MAXC];
    int          m_per;
    int          cyc;
    logic [31:0] exp_ret;
    logic [15:0] exp_mc;
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] b_target(input logic [31:0] ins, input logic [31:0] p);
        int off;
        off = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
        return p + 32'(off);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            m_stall[i] = 1'b0; m_res[i] = 1'b0; m_taken[i] = 1'b0;
            m_target[i] = 32'd0; m_mis[i] = 1'b0; m_ret_d[i] = 0; m_mc_d[i] = 0;
        end
        m_per = 0; exp_ret = 32'd0; exp_mc = 16'd0;
    endtask

    // Present inputs to dut0 for the next edge and schedule the reference outcome.
    task automatic drive0(input bit v, input logic [31:0] ins, input logic [31:0] p, input bit pr, input bit pv);
        int e;
        bit tk;
        bit mis;
        bus0.instruction_valid = v; bus0.instruction = ins; bus0.pc = p;
        bus0.prediction = pr; bus0.prediction_valid = pv;
        e = cyc + 1;
        if (v && !rst && !m_stall[cyc]) begin
            m_ret_d[e] += 1;
            if (ins[6:0] == 7'b1100011) begin
                tk  = ins[12];
                mis = ((pv ? pr : 1'b0) != tk);
                for (int k = 0; k < LAT; k++) m_stall[e + k] = 1'b1;
                m_res[e + LAT - 1]    = 1'b1;
                m_taken[e + LAT - 1]  = tk;
                m_target[e + LAT - 1] = b_target(ins, p);
                m_mis[e + LAT - 1]    = mis;
                if (mis) begin
                    m_stall[e + LAT] = 1'b1;
                    m_mc_d[e + LAT - 1] += 1;
                end
            end else begin
                m_per++;
                if (m_per == EVERY) begin
                    m_stall[e] = 1'b1;
                    m_per = 0;
                end
            end
        end
    endtask

    task automatic drive1(input bit v, input logic [31:0] ins, input logic [31:0] p, input bit pr, input bit pv);
        bus1.instruction_valid = v; bus1.instruction = ins; bus1.pc = p;
        bus1.prediction = pr; bus1.prediction_valid = pv;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (STATS) begin
            exp_ret += 32'(m_ret_d[cyc]);
            exp_mc  += 16'(m_mc_d[cyc]);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        model_clear();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        model_clear();
        tick(); tick();
        n_vec++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", bus0.stall); end
        n_vec++; if (bus0.branch_resolved !== 1'b0) begin n_err++; $display("FAIL reset_resolved got=%b exp=0", bus0.branch_resolved); end
        n_vec++; if (bus0.branch_target !== 32'd0) begin n_err++; $display("FAIL reset_target got=%h exp=0", bus0.branch_target); end
        n_vec++; if (bus0.retired_count !== 32'd0) begin n_err++; $display("FAIL reset_retired got=%0d exp=0", bus0.retired_count); end
        n_vec++; if (bus1.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall1 got=%b exp=0", bus1.stall); end
        rst = 1'b0;
        drive0(1'b1, NOP, 32'h40, 1'b0, 1'b0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (bus0.retired_count !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL first_accept_retired got=%0d exp=%0d", bus0.retired_count, STATS ? 1 : 0); end
    endtask

    task automatic test_periodic();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL periodic_pre_stall i=%0d got=%b exp=0", i, bus0.stall); end
            drive0(1'b1, NOP, 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        n_vec++; if (bus0.stall !== 1'b1) begin n_err++; $display("FAIL periodic_stall got=%b exp=1", bus0.stall); end
        n_vec++; if (bus0.retired_count !== (STATS ? 32'd8 : 32'd0)) begin n_err++; $display("FAIL periodic_retired got=%0d exp=%0d", bus0.retired_count, STATS ? 8 : 0); end
        drive0(1'b1, NOP, 32'h20, 1'b0, 1'b0);
        tick();
        n_vec++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL periodic_stall_end got=%b exp=0", bus0.stall); end
        n_vec++; if (bus0.retired_count !== (STATS ? 32'd8 : 32'd0)) begin n_err++; $display("FAIL periodic_blocked got=%0d exp=%0d", bus0.retired_count, STATS ? 8 : 0); end
        drive0(1'b1, NOP, 32'h20, 1'b0, 1'b0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (bus0.retired_count !== (STATS ? 32'd9 : 32'd0)) begin n_err++; $display("FAIL periodic_resume got=%0d exp=%0d", bus0.retired_count, STATS ? 9 : 0); end
    endtask

    task automatic test_branch_mispredict();
        apply_reset();
        drive0(1'b1, 32'h0000_1463, 32'h100, 1'b0, 1'b0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (bus0.stall !== 1'b1) begin n_err++; $display("FAIL bm_stall_t1 got=%b exp=1", bus0.stall); end
        n_vec++; if (bus0.branch_resolved !== 1'b0) begin n_err++; $display("FAIL bm_early_res got=%b exp=0", bus0.branch_resolved); end
        tick();
        n_vec++; if (bus0.branch_resolved !== 1'b1) begin n_err++; $display("FAIL bm_res got=%b exp=1", bus0.branch_resolved); end
        n_vec++; if (bus0.branch_taken !== 1'b1) begin n_err++; $display("FAIL bm_taken got=%b exp=1", bus0.branch_taken); end
        n_vec++; if (bus0.branch_target !== 32'h108) begin n_err++; $display("FAIL bm_target got=%h exp=00000108", bus0.branch_target); end
        n_vec++; if (bus0.mispredict !== 1'b1) begin n_err++; $display("FAIL bm_mis got=%b exp=1", bus0.mispredict); end
        n_vec++; if (bus0.mispredict_count !== (STATS ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL bm_mcount got=%0d exp=%0d", bus0.mispredict_count, STATS ? 1 : 0); end
        tick();
        n_vec++; if (bus0.stall !== 1'b1) begin n_err++; $display("FAIL bm_flush_stall got=%b exp=1", bus0.stall); end
        n_vec++; if ({bus0.branch_resolved, bus0.branch_taken, bus0.mispredict} !== 3'b000) begin n_err++; $display("FAIL bm_flush_quiet got=%b exp=000", {bus0.branch_resolved, bus0.branch_taken, bus0.mispredict}); end
        n_vec++; if (bus0.branch_target !== 32'd0) begin n_err++; $display("FAIL bm_flush_target got=%h exp=0", bus0.branch_target); end
        drive0(1'b1, NOP, 32'h104, 1'b0, 1'b0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL bm_idle_stall got=%b exp=0", bus0.stall); end
        n_vec++; if (bus0.retired_count !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL bm_flush_ignored got=%0d exp=%0d", bus0.retired_count, STATS ? 1 : 0); end
    endtask

    task automatic test_branch_correct();
        apply_reset();
        drive0(1'b1, 32'h0000_0463, 32'h200, 1'b0, 1'b1);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (bus0.branch_resolved !== 1'b1) begin n_err++; $display("FAIL bc_res got=%b exp=1", bus0.branch_resolved); end
        n_vec++; if (bus0.branch_taken !== 1'b0) begin n_err++; $display("FAIL bc_taken got=%b exp=0", bus0.branch_taken); end
        n_vec++; if (bus0.mispredict !== 1'b0) begin n_err++; $display("FAIL bc_mis got=%b exp=0", bus0.mispredict); end
        n_vec++; if (bus0.branch_target !== 32'h208) begin n_err++; $display("FAIL bc_target got=%h exp=00000208", bus0.branch_target); end
        tick();
        n_vec++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL bc_no_flush got=%b exp=0", bus0.stall); end
    endtask

    task automatic test_backward();
        apply_reset();
        drive0(1'b1, 32'hFE00_1EE3, 32'h0, 1'b1, 1'b1);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (bus0.branch_target !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL bw_target got=%h exp=fffffffc", bus0.branch_target); end
        n_vec++; if (bus0.branch_taken !== 1'b1) begin n_err++; $display("FAIL bw_taken got=%b exp=1", bus0.branch_taken); end
        n_vec++; if (bus0.mispredict !== 1'b0) begin n_err++; $display("FAIL bw_mis got=%b exp=0", bus0.mispredict); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive0(1'b1, 32'h0000_1463, 32'h100, 1'b0, 1'b0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        model_clear();
        #1;
        n_vec++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL rm_stall got=%b exp=0", bus0.stall); end
        n_vec++; if (bus0.branch_resolved !== 1'b0) begin n_err++; $display("FAIL rm_res got=%b exp=0", bus0.branch_resolved); end
        n_vec++; if (bus0.retired_count !== 32'd0) begin n_err++; $display("FAIL rm_retired got=%0d exp=0", bus0.retired_count); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if ({bus0.branch_resolved, bus0.stall} !== 2'b00) begin n_err++; $display("FAIL rm_after i=%0d got=%b exp=00", i, {bus0.branch_resolved, bus0.stall}); end
        end
    endtask

    task automatic test_lat1();
        apply_reset();
        drive1(1'b1, 32'h0000_1463, 32'h100, 1'b0, 1'b0);
        tick();
        drive1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if ({bus1.branch_resolved, bus1.stall, bus1.branch_taken, bus1.mispredict} !== 4'b1111) begin n_err++; $display("FAIL l1_res got=%b exp=1111", {bus1.branch_resolved, bus1.stall, bus1.branch_taken, bus1.mispredict}); end
        n_vec++; if (bus1.branch_target !== 32'h108) begin n_err++; $display("FAIL l1_target got=%h exp=00000108", bus1.branch_target); end
        tick();
        n_vec++; if ({bus1.branch_resolved, bus1.stall} !== 2'b01) begin n_err++; $display("FAIL l1_flush got=%b exp=01", {bus1.branch_resolved, bus1.stall}); end
        tick();
        n_vec++; if (bus1.stall !== 1'b0) begin n_err++; $display("FAIL l1_idle got=%b exp=0", bus1.stall); end
        drive1(1'b1, 32'h0000_0463, 32'h200, 1'b0, 1'b1);
        tick();
        drive1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if ({bus1.branch_resolved, bus1.stall, bus1.mispredict} !== 3'b110) begin n_err++; $display("FAIL l1_ok got=%b exp=110", {bus1.branch_resolved, bus1.stall, bus1.mispredict}); end
        tick();
        n_vec++; if (bus1.stall !== 1'b0) begin n_err++; $display("FAIL l1_ok_idle got=%b exp=0", bus1.stall); end
        for (int i = 0; i < 10; i++) begin
            drive1(1'b1, NOP, 32'(i * 4), 1'b0, 1'b0);
            tick();
            n_vec++; if (bus1.stall !== 1'b0) begin n_err++; $display("FAIL l1_no_periodic i=%0d got=%b exp=0", i, bus1.stall); end
        end
        drive1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (bus1.retired_count !== (STATS ? 32'd12 : 32'd0)) begin n_err++; $display("FAIL l1_retired got=%0d exp=%0d", bus1.retired_count, STATS ? 12 : 0); end
        n_vec++; if (bus1.mispredict_count !== (STATS ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL l1_mcount got=%0d exp=%0d", bus1.mispredict_count, STATS ? 1 : 0); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            n_vec++; if (bus0.stall !== m_stall[cyc]) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, bus0.stall, m_stall[cyc]); end
            n_vec++; if (bus0.branch_resolved !== m_res[cyc]) begin n_err++; $display("FAIL rnd_res cyc=%0d got=%b exp=%b", cyc, bus0.branch_resolved, m_res[cyc]); end
            n_vec++; if (bus0.branch_taken !== m_taken[cyc]) begin n_err++; $display("FAIL rnd_taken cyc=%0d got=%b exp=%b", cyc, bus0.branch_taken, m_taken[cyc]); end
            n_vec++; if (bus0.branch_target !== m_target[cyc]) begin n_err++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", cyc, bus0.branch_target, m_target[cyc]); end
            n_vec++; if (bus0.mispredict !== m_mis[cyc]) begin n_err++; $display("FAIL rnd_mis cyc=%0d got=%b exp=%b", cyc, bus0.mispredict, m_mis[cyc]); end
            n_vec++; if (bus0.retired_count !== exp_ret) begin n_err++; $display("FAIL rnd_retired cyc=%0d got=%0d exp=%0d", cyc, bus0.retired_count, exp_ret); end
            n_vec++; if (bus0.mispredict_count !== exp_mc) begin n_err++; $display("FAIL rnd_mcount cyc=%0d got=%0d exp=%0d", cyc, bus0.mispredict_count, exp_mc); end
            if ($urandom_range(0, 249) == 0) begin
                apply_reset();
            end else begin
                ins = $urandom;
                if ($urandom_range(0, 2) == 0) ins[6:0] = 7'b1100011;
                drive0($urandom_range(0, 3) != 0, ins, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                tick();
            end
        end
        drive0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        test_reset();
        test_periodic();
        test_branch_mispredict();
        test_branch_correct();
        test_backward();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
